// File: rtl/dw02_mult_6_stage.sv
// Six-stage pipelined multiplier: capture, operand extension, partial products,
// pairwise reduction, split final add (low half, then high half with carry).
module dw02_mult_6_stage #(
    parameter int A_width = 8,
    parameter int B_width = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [A_width-1:0]         a,
    input  logic [B_width-1:0]         b,
    input  logic                       tc,
    output logic [A_width+B_width-1:0] product
);

    localparam int W  = A_width + B_width;
    localparam int HL = W / 2;
    localparam int HH = W - HL;

    // Stage 0: raw operand capture
    logic [A_width-1:0] a_q, a_d;
    logic [B_width-1:0] b_q, b_d;
    logic               tc_q, tc_d;
    // Stage 1: operands extended to full product width
    logic [W-1:0]       a_ext_q, a_ext_d, b_ext_q, b_ext_d;
    // Stage 2: four half-by-half partial products, already shifted into place
    logic [W-1:0]       pp_ll_q, pp_ll_d, pp_lh_q, pp_lh_d;
    logic [W-1:0]       pp_hl_q, pp_hl_d, pp_hh_q, pp_hh_d;
    // Stage 3: two reduced addends
    logic [W-1:0]       sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    // Stage 4: low half of the final add plus its carry
    logic [HL-1:0]      lo_q, lo_d;
    logic               carry_q, carry_d;
    logic [HH-1:0]      x_hi_q, x_hi_d, y_hi_q, y_hi_d;
    // Stage 5: output register
    logic [W-1:0]       product_q, product_d;

    logic [HL-1:0]      a_lo, b_lo;
    logic [HH-1:0]      a_hi, b_hi;
    logic [HH-1:0]      hi_sum;

    always_comb begin
        a_d  = a;
        b_d  = b;
        tc_d = tc;

        // Multiplying the W-bit extensions modulo 2^W yields the exact product
        // in both modes, so the rest of the datapath is sign-agnostic.
        a_ext_d = {{B_width{tc_q & a_q[A_width-1]}}, a_q};
        b_ext_d = {{A_width{tc_q & b_q[B_width-1]}}, b_q};

        a_lo = a_ext_q[HL-1:0];
        a_hi = a_ext_q[W-1:HL];
        b_lo = b_ext_q[HL-1:0];
        b_hi = b_ext_q[W-1:HL];

        pp_ll_d = W'(a_lo) * W'(b_lo);
        pp_lh_d = (W'(a_lo) * W'(b_hi)) << HL;
        pp_hl_d = (W'(a_hi) * W'(b_lo)) << HL;
        pp_hh_d = (W'(a_hi) * W'(b_hi)) << (2 * HL);

        sum_x_d = pp_ll_q + pp_lh_q;
        sum_y_d = pp_hl_q + pp_hh_q;

        {carry_d, lo_d} = {1'b0, sum_x_q[HL-1:0]} + {1'b0, sum_y_q[HL-1:0]};
        x_hi_d = sum_x_q[W-1:HL];
        y_hi_d = sum_y_q[W-1:HL];

        hi_sum    = x_hi_q + y_hi_q + HH'(carry_q);
        product_d = {hi_sum, lo_q};
    end

    // NOTE: synchronous reset clears every stage so in-flight pairs are flushed;
    // all state uses non-blocking assignments so stages update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            tc_q      <= 1'b0;
            a_ext_q   <= '0;
            b_ext_q   <= '0;
            pp_ll_q   <= '0;
            pp_lh_q   <= '0;
            pp_hl_q   <= '0;
            pp_hh_q   <= '0;
            sum_x_q   <= '0;
            sum_y_q   <= '0;
            lo_q      <= '0;
            carry_q   <= 1'b0;
            x_hi_q    <= '0;
            y_hi_q    <= '0;
            product_q <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            tc_q      <= tc_d;
            a_ext_q   <= a_ext_d;
            b_ext_q   <= b_ext_d;
            pp_ll_q   <= pp_ll_d;
            pp_lh_q   <= pp_lh_d;
            pp_hl_q   <= pp_hl_d;
            pp_hh_q   <= pp_hh_d;
            sum_x_q   <= sum_x_d;
            sum_y_q   <= sum_y_d;
            lo_q      <= lo_d;
            carry_q   <= carry_d;
            x_hi_q    <= x_hi_d;
            y_hi_q    <= y_hi_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_dw02_mult_6_stage.sv
// Randomized and directed bench for dw02_mult_6_stage against an arithmetic
// reference and a five-edge latency queue.
module tb_dw02_mult_6_stage;

    localparam int AW  = 8;
    localparam int BW  = 8;
    localparam int PW  = AW + BW;
    localparam int LAT = 5;

    logic          clk;
    logic          reset;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          tc;
    logic [PW-1:0] product;

    int errors = 0;
    int checks = 0;

    // Values issued on past edges, newest first; a reset edge wipes them all.
    logic [PW-1:0] issued_q[$];

    dw02_mult_6_stage #(.A_width(AW), .B_width(BW)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .tc      (tc),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] ref_mult(input logic [AW-1:0] x,
                                               input logic [BW-1:0] y,
                                               input logic          t);
        longint sx, sy;
        sx = t ? longint'($signed(x)) : longint'(x);
        sy = t ? longint'($signed(y)) : longint'(y);
        return PW'(sx * sy);
    endfunction

    // Apply inputs, take one rising edge, advance the model and return what
    // product must read just after that edge.
    task automatic cycle(input logic [AW-1:0] ai, input logic [BW-1:0] bi,
                         input logic ti, input logic ri,
                         output logic [PW-1:0] exp_o);
        a = ai; b = bi; tc = ti; reset = ri;
        @(posedge clk);
        if (ri) begin
            foreach (issued_q[i]) issued_q[i] = '0;
            issued_q.push_front('0);
        end else begin
            issued_q.push_front(ref_mult(ai, bi, ti));
        end
        while (issued_q.size() > LAT + 1) void'(issued_q.pop_back());
        exp_o = (issued_q.size() == LAT + 1) ? issued_q[LAT] : '0;
        #1;
    endtask

    task automatic test_reset();
        logic [PW-1:0] e;
        for (int i = 0; i < 2; i++) begin
            cycle(8'd5, 8'd5, 1'b1, 1'b1, e);
            checks++;
            if (product !== '0) begin
                $display("FAIL reset_hold edge%0d: got %h want 0000", i, product);
                errors++;
            end
        end
        for (int i = 0; i < LAT; i++) begin
            cycle('0, '0, 1'b0, 1'b0, e);
            checks++;
            if (product !== '0 || product !== e) begin
                $display("FAIL reset_release edge%0d: got %h want 0000", i, product);
                errors++;
            end
        end
    endtask

    task automatic test_latency();
        logic [PW-1:0] e;
        logic [PW-1:0] want;
        cycle(8'd3, 8'd3, 1'b1, 1'b0, e);
        for (int k = 1; k <= 6; k++) begin
            cycle('0, '0, 1'b1, 1'b0, e);
            want = (k == 5) ? 16'd9 : 16'd0;
            checks++;
            if (product !== want) begin
                $display("FAIL latency edge N+%0d: got %h want %h", k, product, want);
                errors++;
            end
        end
    endtask

    // Issue a list of pairs back to back and check each result 5 edges later.
    task automatic run_list(input string name, input logic [AW-1:0] av[],
                            input logic [BW-1:0] bv[], input logic tv[],
                            input logic [PW-1:0] want[]);
        logic [PW-1:0] e;
        int n;
        n = av.size();
        for (int k = 0; k < n + LAT; k++) begin
            if (k < n) cycle(av[k], bv[k], tv[k], 1'b0, e);
            else       cycle('0, '0, 1'b0, 1'b0, e);
            if (k >= LAT) begin
                checks++;
                if (product !== want[k-LAT]) begin
                    $display("FAIL %s item%0d: got %h want %h", name, k - LAT,
                             product, want[k-LAT]);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_signed_corners();
        logic [AW-1:0] av[] = '{8'h80, 8'h80, 8'hFF};
        logic [BW-1:0] bv[] = '{8'h80, 8'h7F, 8'h01};
        logic          tv[] = '{1'b1, 1'b1, 1'b1};
        logic [PW-1:0] wv[] = '{16'h4000, 16'hC080, 16'hFFFF};
        run_list("signed_corner", av, bv, tv, wv);
    endtask

    task automatic test_unsigned_corners();
        logic [AW-1:0] av[] = '{8'hFF, 8'h80, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h80};
        logic [BW-1:0] bv[] = '{8'hFF, 8'h02, 8'hFF, 8'hFF, 8'h02, 8'h02, 8'h7F};
        logic          tv[] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [PW-1:0] wv[] = '{16'hFE01, 16'h0100, 16'h0001, 16'hFE01,
                                16'hFF00, 16'h0100, 16'hC080};
        run_list("tc_toggle", av, bv, tv, wv);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] av[] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        logic          tv[] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [PW-1:0] wv[] = '{16'd1, 16'd4, 16'd9, 16'd16, 16'd25, 16'd36};
        run_list("stream", av, av, tv, wv);
    endtask

    task automatic test_midstream_reset();
        logic [PW-1:0] e;
        cycle(8'd2, 8'd2, 1'b1, 1'b0, e);
        cycle(8'd3, 8'd3, 1'b1, 1'b0, e);
        cycle(8'd7, 8'd7, 1'b1, 1'b1, e);
        checks++;
        if (product !== '0) begin
            $display("FAIL midreset at_reset: got %h want 0000", product);
            errors++;
        end
        for (int k = 0; k < LAT + 2; k++) begin
            cycle('0, '0, 1'b1, 1'b0, e);
            checks++;
            if (product !== '0) begin
                $display("FAIL midreset flush edge%0d: got %h want 0000", k, product);
                errors++;
            end
        end
    endtask

    task automatic test_random();
        logic [PW-1:0] e;
        logic [AW-1:0] ra;
        logic [BW-1:0] rb;
        logic          rt, rr;
        for (int k = 0; k < 300; k++) begin
            ra = AW'($urandom);
            rb = BW'($urandom);
            rt = 1'($urandom);
            rr = ($urandom_range(0, 31) == 0);
            cycle(ra, rb, rt, rr, e);
            checks++;
            if (product !== e) begin
                $display("FAIL random cyc%0d: got %h want %h", k, product, e);
                errors++;
            end
        end
    endtask

    initial begin
        a = '0; b = '0; tc = 1'b0; reset = 1'b1;
        #2;
        test_reset();
        test_latency();
        test_signed_corners();
        test_unsigned_corners();
        test_back_to_back();
        test_midstream_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
